game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_pkg.sv | 37 +++
 rtl/game_ctrl_bcd_counter4.sv | 36 +++
 rtl/game_ctrl.sv | 116 +++++++++++
 tb/tb_game_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared types, constants and the BCD increment helper for the game controller.
package game_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int unsigned SCORE_W   = 16;
    localparam int unsigned H_VIS_DEF = 640;
    localparam int unsigned V_VIS_DEF = 480;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

    // Add one to a 4-digit BCD value, rippling carries; holds at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != SCORE_MAX_BCD) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD score counter with synchronous clear and saturating increment.
module bcd_counter4
    import game_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next count: clear wins over increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 16'h0000;
        end else if (inc) begin
            q_d = bcd_inc(q_q);
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q <= 16'h0000;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: frame-end detection, collision flag, IDLE/RUN/OVER FSM and score.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_DIV = 6,
    parameter int unsigned H_VIS     = H_VIS_DEF,
    parameter int unsigned V_VIS     = V_VIS_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        fresh,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        dino_px,
    input  logic        obst_px,
    output logic        game_status,
    output logic        game_over,
    output logic [15:0] score
);

    localparam int unsigned FCNT_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SCORE_DIV - 1);

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                hit_q, hit_d;
    logic                fresh_q;
    logic                status_q, status_d;
    logic                over_q, over_d;
    logic                frame_end;
    logic                in_vis;
    logic                hit_now;
    logic                score_clr;
    logic                score_inc;

    // Frame end, visible-area qualified collision, and FSM next state.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        hit_d     = hit_q;
        score_clr = 1'b0;
        score_inc = 1'b0;

        frame_end = fresh_q & ~fresh;
        in_vis    = ({23'd0, row_addr} < V_VIS) && ({22'd0, col_addr} < H_VIS);
        hit_now   = (state_q == ST_RUN) && dino_px && obst_px && in_vis;

        if (hit_now) begin
            hit_d = 1'b1;
        end
        if (frame_end) begin
            hit_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (START) begin
                    state_d   = ST_RUN;
                    fcnt_d    = '0;
                    hit_d     = 1'b0;
                    score_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    if (hit_q || hit_now) begin
                        state_d = ST_OVER;
                    end else if (fcnt_q == FCNT_LAST) begin
                        fcnt_d    = '0;
                        score_inc = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        status_d = (state_d == ST_RUN);
        over_d   = (state_d == ST_OVER);
    end

    // State, frame counter, hit flag, fresh history and status outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= '0;
            hit_q    <= 1'b0;
            fresh_q  <= 1'b0;
            status_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            hit_q    <= hit_d;
            fresh_q  <= fresh;
            status_q <= status_d;
            over_q   <= over_d;
        end
    end

    bcd_counter4 u_score (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score)
    );

    assign game_status = status_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl; a second instance with SCORE_DIV=1 covers the BCD range.
module tb_game_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, START, fresh, dino_px, obst_px;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        game_status, game_over;
    logic [15:0] score;

    logic        rst_f, start_f, fresh_f, px_f;
    logic        status_f, over_f;
    logic [15:0] score_f;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          fast;
        logic        st;
        logic        ov;
        logic [15:0] sc;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    game_ctrl #(.SCORE_DIV(6)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .fresh(fresh),
        .row_addr(row_addr), .col_addr(col_addr),
        .dino_px(dino_px), .obst_px(obst_px),
        .game_status(game_status), .game_over(game_over), .score(score)
    );

    game_ctrl #(.SCORE_DIV(1)) dut_fast (
        .CLK(CLK), .RESET(rst_f), .START(start_f), .fresh(fresh_f),
        .row_addr(row_addr), .col_addr(col_addr),
        .dino_px(px_f), .obst_px(px_f),
        .game_status(status_f), .game_over(over_f), .score(score_f)
    );

    function automatic logic [15:0] to_bcd(input int n);
        int v;
        v = (n > 9999) ? 9999 : n;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    // Pop every queued expectation and compare against the selected instance.
    task automatic check_sb();
        exp_t        e;
        logic        st, ov;
        logic [15:0] sc;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            st = e.fast ? status_f : game_status;
            ov = e.fast ? over_f   : game_over;
            sc = e.fast ? score_f  : score;
            checks++;
            assert (st === e.st) else begin
                errors++;
                $error("FAIL %s game_status got=%0b exp=%0b", e.tag, st, e.st);
            end
            checks++;
            assert (ov === e.ov) else begin
                errors++;
                $error("FAIL %s game_over got=%0b exp=%0b", e.tag, ov, e.ov);
            end
            checks++;
            assert (sc === e.sc) else begin
                errors++;
                $error("FAIL %s score got=%04h exp=%04h", e.tag, sc, e.sc);
            end
        end
    endtask

    task automatic expect_out(input string tag, input bit fast, input logic st,
                              input logic ov, input logic [15:0] sc);
        exp_t e;
        e.tag = tag; e.fast = fast; e.st = st; e.ov = ov; e.sc = sc;
        sb_q.push_back(e);
        check_sb();
    endtask

    task automatic frames_main(input int n);
        for (int i = 0; i < n; i++) begin
            fresh = 1'b1; tick();
            fresh = 1'b0; tick();
        end
    endtask

    task automatic frames_fast(input int n);
        for (int i = 0; i < n; i++) begin
            fresh_f = 1'b1; tick();
            fresh_f = 1'b0; tick();
        end
    endtask

    initial begin
        int pts[8];
        int done;
        pts = '{9, 10, 99, 100, 999, 1000, 9999, 10005};

        RESET = 1'b1; START = 1'b0; fresh = 1'b0;
        dino_px = 1'b0; obst_px = 1'b0; row_addr = 9'd0; col_addr = 10'd0;
        rst_f = 1'b1; start_f = 1'b0; fresh_f = 1'b0; px_f = 1'b0;
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_out("reset_fast", 1'b1, 1'b0, 1'b0, 16'h0000);

        RESET = 1'b0; rst_f = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        expect_out("start", 1'b0, 1'b1, 1'b0, 16'h0000);

        frames_main(5);
        expect_out("five_frames", 1'b0, 1'b1, 1'b0, 16'h0000);
        frames_main(1);
        expect_out("six_frames", 1'b0, 1'b1, 1'b0, 16'h0001);
        frames_main(6);
        expect_out("twelve_frames", 1'b0, 1'b1, 1'b0, 16'h0002);

        // Mid-frame collision holds RUN until the frame ends.
        dino_px = 1'b1; obst_px = 1'b1; row_addr = 9'd300; col_addr = 10'd100;
        fresh = 1'b1; tick();
        dino_px = 1'b0; obst_px = 1'b0;
        tick();
        expect_out("hit_pending", 1'b0, 1'b1, 1'b0, 16'h0002);
        fresh = 1'b0; tick();
        expect_out("hit_over", 1'b0, 1'b0, 1'b1, 16'h0002);
        frames_main(6);
        expect_out("over_frozen", 1'b0, 1'b0, 1'b1, 16'h0002);

        START = 1'b1; tick(); START = 1'b0;
        expect_out("restart_from_over", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Overlap just outside the visible area never counts.
        dino_px = 1'b1; obst_px = 1'b1; row_addr = 9'd479; col_addr = 10'd640;
        frames_main(1);
        row_addr = 9'd480; col_addr = 10'd639;
        frames_main(1);
        dino_px = 1'b0; obst_px = 1'b0;
        expect_out("outside_no_hit", 1'b0, 1'b1, 1'b0, 16'h0000);

        // Collision on the same cycle as frame end.
        fresh = 1'b1; tick();
        dino_px = 1'b1; obst_px = 1'b1; row_addr = 9'd479; col_addr = 10'd639;
        fresh = 1'b0; tick();
        dino_px = 1'b0; obst_px = 1'b0;
        expect_out("hit_at_frame_end", 1'b0, 1'b0, 1'b1, 16'h0000);

        // Reset mid-RUN with a hit pending and a score increment due.
        START = 1'b1; tick(); START = 1'b0;
        frames_main(6);
        expect_out("score_before_reset", 1'b0, 1'b1, 1'b0, 16'h0001);
        frames_main(5);
        dino_px = 1'b1; obst_px = 1'b1; row_addr = 9'd10; col_addr = 10'd10;
        fresh = 1'b1; tick();
        dino_px = 1'b0; obst_px = 1'b0;
        fresh = 1'b0; RESET = 1'b1; tick();
        RESET = 1'b0;
        expect_out("reset_mid_run", 1'b0, 1'b0, 1'b0, 16'h0000);
        frames_main(2);
        expect_out("idle_holds", 1'b0, 1'b0, 1'b0, 16'h0000);

        START = 1'b1; tick(); START = 1'b0;
        expect_out("start_after_reset", 1'b0, 1'b1, 1'b0, 16'h0000);
        frames_main(5994);
        expect_out("score_0999", 1'b0, 1'b1, 1'b0, 16'h0999);
        frames_main(6);
        expect_out("score_1000", 1'b0, 1'b1, 1'b0, 16'h1000);
        START = 1'b1;
        frames_main(6);
        START = 1'b0;
        expect_out("start_ignored_in_run", 1'b0, 1'b1, 1'b0, 16'h1001);

        // Fast instance: one score step per frame, walk the carry boundaries.
        start_f = 1'b1; tick(); start_f = 1'b0;
        expect_out("fast_start", 1'b1, 1'b1, 1'b0, 16'h0000);
        done = 0;
        foreach (pts[k]) begin
            frames_fast(pts[k] - done);
            done = pts[k];
            expect_out($sformatf("fast_%0d", pts[k]), 1'b1, 1'b1, 1'b0, to_bcd(pts[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
